// File: rtl/switch_power_test_sequencer_pkg.sv
// Shared mode encodings, sequencer state codes and the phase-selection helper
// for the switch power test sequencer.
package switch_power_test_sequencer_pkg;

  localparam int MODEWIDTH = 3;
  localparam int NUMMODES  = 5;

  typedef enum logic [MODEWIDTH-1:0] {
    MODE_IDLE          = 3'd0,
    MODE_THROUGH       = 3'd1,
    MODE_CONGESTION    = 3'd2,
    MODE_NOARBITRATION = 3'd3,
    MODE_ROTATE        = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic                 found;
    logic [MODEWIDTH-1:0] idx;
  } pick_t;

  // Lowest enabled mode encoding at or above 'from'.
  function automatic pick_t pick_from(input logic [NUMMODES-1:0] mask,
                                      input logic [MODEWIDTH-1:0] from);
    pick_t p;
    p.found = 1'b0;
    p.idx   = '0;
    for (int i = NUMMODES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        p.found = 1'b1;
        p.idx   = MODEWIDTH'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/switch_power_test_sequencer_quiet.sv
// Drain watcher: counts drain cycles and consecutive idle cycles at the switch
// outputs, flagging when the current cycle completes the quiet window or the timeout.
module switch_power_quiet_detector #(
  parameter int NUMPORTS     = 5,
  parameter int CNTWIDTH     = 16,
  parameter int QUIETCYCLES  = 8,
  parameter int DRAINTIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [NUMPORTS-1:0] valid,
  output logic                quiet,
  output logic                timeout
);

  logic [CNTWIDTH-1:0] quiet_cnt;
  logic [CNTWIDTH-1:0] drain_cnt;
  logic [CNTWIDTH-1:0] quiet_next;
  logic [CNTWIDTH-1:0] drain_next;

  function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
    return (&v) ? v : v + CNTWIDTH'(1);
  endfunction

  assign quiet_next = (|valid) ? '0 : sat_inc(quiet_cnt);
  assign drain_next = sat_inc(drain_cnt);
  assign quiet      = (quiet_next >= CNTWIDTH'(QUIETCYCLES));
  assign timeout    = (drain_next >= CNTWIDTH'(DRAINTIMEOUT));

  // Counters run only while the sequencer is draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quiet_cnt <= '0;
      drain_cnt <= '0;
    end else if (clear) begin
      quiet_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      quiet_cnt <= quiet_next;
      drain_cnt <= drain_next;
    end
  end

endmodule

// File: rtl/switch_power_test_sequencer.sv
// Runtime controller stepping the source/sink testers through each enabled
// testing mode: inject for a fixed count, then drain until the switch is quiet.
module switch_power_test_sequencer
  import switch_power_test_sequencer_pkg::*;
#(
  parameter int                  NUMPORTS     = 5,
  parameter int                  CNTWIDTH     = 16,
  parameter int                  PHASECYCLES  = 1000,
  parameter int                  QUIETCYCLES  = 8,
  parameter int                  DRAINTIMEOUT = 4096,
  parameter logic [NUMMODES-1:0] MODEMASK     = 5'b11110,
  parameter bit                  LOOP         = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 START_in,
  input  logic                 ABORT_in,
  input  logic [NUMPORTS-1:0]  VALID_in,
  output logic [MODEWIDTH-1:0] MODE_out,
  output logic                 INJECT_EN_out,
  output logic [MODEWIDTH-1:0] PHASE_IDX_out,
  output logic                 PHASE_DONE_out,
  output logic                 DONE_out,
  output logic                 TIMEOUT_out,
  output logic                 ABORTED_out
);

  localparam int                  RUNCYCLES = (PHASECYCLES < 1) ? 1 : PHASECYCLES;
  localparam logic [CNTWIDTH-1:0] RUNLOAD   = CNTWIDTH'(RUNCYCLES - 1);

  seq_state_e           state;
  logic [CNTWIDTH-1:0]  run_cnt;
  logic                 abort_latched;
  logic                 has_last;
  logic [MODEWIDTH-1:0] last_idx;
  logic                 abort_now;
  logic                 quiet_hit;
  logic                 timeout_hit;
  pick_t                next_pick;
  pick_t                wrap_pick;
  pick_t                pick;

  assign abort_now = abort_latched | ABORT_in;
  assign next_pick = pick_from(MODEMASK, has_last ? last_idx + MODEWIDTH'(1) : MODEWIDTH'(0));
  assign wrap_pick = pick_from(MODEMASK, MODEWIDTH'(0));

  // Next phase: strictly above the last run one, else wrap when looping.
  always_comb begin
    if (next_pick.found) begin
      pick = next_pick;
    end else if (LOOP) begin
      pick = wrap_pick;
    end else begin
      pick = '0;
    end
  end

  switch_power_quiet_detector #(
    .NUMPORTS    (NUMPORTS),
    .CNTWIDTH    (CNTWIDTH),
    .QUIETCYCLES (QUIETCYCLES),
    .DRAINTIMEOUT(DRAINTIMEOUT)
  ) u_quiet (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != S_DRAIN),
    .valid  (VALID_in),
    .quiet  (quiet_hit),
    .timeout(timeout_hit)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      run_cnt        <= '0;
      abort_latched  <= 1'b0;
      has_last       <= 1'b0;
      last_idx       <= '0;
      MODE_out       <= MODE_IDLE;
      INJECT_EN_out  <= 1'b0;
      PHASE_IDX_out  <= '0;
      PHASE_DONE_out <= 1'b0;
      DONE_out       <= 1'b0;
      TIMEOUT_out    <= 1'b0;
      ABORTED_out    <= 1'b0;
    end else begin
      PHASE_DONE_out <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (START_in) begin
            state         <= S_SELECT;
            DONE_out      <= 1'b0;
            TIMEOUT_out   <= 1'b0;
            ABORTED_out   <= 1'b0;
            abort_latched <= 1'b0;
            has_last      <= 1'b0;
          end
        end
        S_SELECT: begin
          if (abort_now) begin
            state       <= S_DONE;
            DONE_out    <= 1'b1;
            MODE_out    <= MODE_IDLE;
            ABORTED_out <= 1'b1;
          end else if (pick.found) begin
            state         <= S_RUN;
            MODE_out      <= pick.idx;
            PHASE_IDX_out <= pick.idx;
            last_idx      <= pick.idx;
            has_last      <= 1'b1;
            INJECT_EN_out <= 1'b1;
            run_cnt       <= RUNLOAD;
          end else begin
            state    <= S_DONE;
            DONE_out <= 1'b1;
            MODE_out <= MODE_IDLE;
          end
        end
        S_RUN: begin
          abort_latched <= abort_now;
          if (ABORT_in || (run_cnt == '0)) begin
            state         <= S_DRAIN;
            INJECT_EN_out <= 1'b0;
          end else begin
            run_cnt <= run_cnt - CNTWIDTH'(1);
          end
        end
        S_DRAIN: begin
          abort_latched <= abort_now;
          if (quiet_hit || timeout_hit) begin
            PHASE_DONE_out <= 1'b1;
            if (timeout_hit) begin
              TIMEOUT_out <= 1'b1;
            end
            if (abort_now) begin
              state       <= S_DONE;
              DONE_out    <= 1'b1;
              MODE_out    <= MODE_IDLE;
              ABORTED_out <= 1'b1;
            end else begin
              state <= S_SELECT;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_power_test_sequencer.sv
// Randomized bench: a phase-level model expands each test sequence into
// per-cycle stimulus and expected outputs for three differently configured instances.
module tb_switch_power_test_sequencer;

  localparam int NP = 5;

  typedef struct packed {
    logic          start;
    logic          abort;
    logic [NP-1:0] valid;
    logic [10:0]   exp;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start_s [3];
  logic          abort_s [3];
  logic [NP-1:0] valid_s [3];
  logic [2:0]    mode_s  [3];
  logic [2:0]    pidx_s  [3];
  logic          inj_s   [3];
  logic          pdone_s [3];
  logic          done_s  [3];
  logic          to_s    [3];
  logic          ab_s    [3];
  logic [10:0]   obs     [3];

  rec_t       q[$];
  logic [2:0] m_pidx [3];
  logic       m_done [3];
  logic       m_to   [3];
  logic       m_ab   [3];
  int         n_checks = 0;
  int         n_pass   = 0;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      obs[i] = {mode_s[i], inj_s[i], pidx_s[i], pdone_s[i], done_s[i], to_s[i], ab_s[i]};
    end
  end

  switch_power_test_sequencer #(.NUMPORTS(NP), .CNTWIDTH(16), .PHASECYCLES(4), .QUIETCYCLES(8),
    .DRAINTIMEOUT(16), .MODEMASK(5'b11110), .LOOP(1'b0)) u_main (
    .clk(clk), .rst(rst), .START_in(start_s[0]), .ABORT_in(abort_s[0]), .VALID_in(valid_s[0]),
    .MODE_out(mode_s[0]), .INJECT_EN_out(inj_s[0]), .PHASE_IDX_out(pidx_s[0]),
    .PHASE_DONE_out(pdone_s[0]), .DONE_out(done_s[0]), .TIMEOUT_out(to_s[0]), .ABORTED_out(ab_s[0]));

  switch_power_test_sequencer #(.NUMPORTS(NP), .CNTWIDTH(16), .PHASECYCLES(4), .QUIETCYCLES(8),
    .DRAINTIMEOUT(16), .MODEMASK(5'b00000), .LOOP(1'b1)) u_empty (
    .clk(clk), .rst(rst), .START_in(start_s[1]), .ABORT_in(abort_s[1]), .VALID_in(valid_s[1]),
    .MODE_out(mode_s[1]), .INJECT_EN_out(inj_s[1]), .PHASE_IDX_out(pidx_s[1]),
    .PHASE_DONE_out(pdone_s[1]), .DONE_out(done_s[1]), .TIMEOUT_out(to_s[1]), .ABORTED_out(ab_s[1]));

  switch_power_test_sequencer #(.NUMPORTS(NP), .CNTWIDTH(16), .PHASECYCLES(0), .QUIETCYCLES(8),
    .DRAINTIMEOUT(16), .MODEMASK(5'b00010), .LOOP(1'b0)) u_short (
    .clk(clk), .rst(rst), .START_in(start_s[2]), .ABORT_in(abort_s[2]), .VALID_in(valid_s[2]),
    .MODE_out(mode_s[2]), .INJECT_EN_out(inj_s[2]), .PHASE_IDX_out(pidx_s[2]),
    .PHASE_DONE_out(pdone_s[2]), .DONE_out(done_s[2]), .TIMEOUT_out(to_s[2]), .ABORTED_out(ab_s[2]));

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {mode,inj,pidx,pdone,done,to,ab}=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic rnd_start();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic push(input logic st, input logic ab_in, input logic [NP-1:0] v,
                      input logic [2:0] md, input logic inj, input logic [2:0] pi,
                      input logic pd, input logic dn, input logic to, input logic ab);
    rec_t r;
    r.start = st;
    r.abort = ab_in;
    r.valid = v;
    r.exp   = {md, inj, pi, pd, dn, to, ab};
    q.push_back(r);
  endtask

  // One full sequence from a start request: per enabled mode a select cycle,
  // max(pc,1) inject cycles (cut short by an abort) and a drain that ends on
  // qc consecutive idle cycles or after tc cycles.
  task automatic gen_seq(input int dut, input logic [4:0] mask, input int pc, input int qc,
                         input int tc, input int abort_mode, input int abort_cyc);
    int            p;
    int            runlen;
    int            z;
    int            pct;
    logic [2:0]    cur;
    logic          pd;
    logic          aborted;
    logic [NP-1:0] v;
    p = (pc < 1) ? 1 : pc;
    push(1'b1, 1'b0, '0, 3'd0, 1'b0, m_pidx[dut], 1'b0, m_done[dut], m_to[dut], m_ab[dut]);
    m_done[dut] = 1'b0;
    m_to[dut]   = 1'b0;
    m_ab[dut]   = 1'b0;
    cur = 3'd0;
    pd = 1'b0;
    aborted = 1'b0;
    for (int md = 0; md < 5; md++) begin
      if (mask[md] && !aborted) begin
        push(1'b0, 1'b0, '0, cur, 1'b0, m_pidx[dut], pd, 1'b0, m_to[dut], 1'b0);
        cur = 3'(md);
        m_pidx[dut] = 3'(md);
        pd = 1'b0;
        runlen = (md == abort_mode) ? abort_cyc : p;
        for (int j = 0; j < runlen; j++) begin
          push(rnd_start(), (md == abort_mode) && (j == runlen - 1), NP'($urandom_range(0, 31)),
               cur, 1'b1, cur, 1'b0, 1'b0, m_to[dut], 1'b0);
        end
        pct = 30 * int'($urandom_range(0, 3));
        z = 0;
        for (int j = 0; j < tc; j++) begin
          v = (int'($urandom_range(0, 99)) < pct) ? NP'($urandom_range(1, 31)) : '0;
          push(rnd_start(), 1'b0, v, cur, 1'b0, cur, 1'b0, 1'b0, m_to[dut], 1'b0);
          z = (v == '0) ? z + 1 : 0;
          if (z >= qc || j + 1 >= tc) begin
            if (j + 1 >= tc) m_to[dut] = 1'b1;
            break;
          end
        end
        pd = 1'b1;
        aborted = (md == abort_mode);
      end
    end
    if (!aborted) begin
      push(1'b0, 1'b0, '0, cur, 1'b0, m_pidx[dut], pd, 1'b0, m_to[dut], 1'b0);
      pd = 1'b0;
    end
    m_ab[dut]   = aborted;
    m_done[dut] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 1'($urandom_range(0, 1)), NP'($urandom_range(0, 31)),
           3'd0, 1'b0, m_pidx[dut], pd, 1'b1, m_to[dut], m_ab[dut]);
      pd = 1'b0;
    end
  endtask

  task automatic run_q(input int dut, input int limit);
    rec_t r;
    int   n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      r = q.pop_front();
      check($sformatf("dut%0d_cyc%0d", dut, n), obs[dut], r.exp);
      start_s[dut] = r.start;
      abort_s[dut] = r.abort;
      valid_s[dut] = r.valid;
      @(posedge clk);
      #1;
      n++;
    end
    start_s[dut] = 1'b0;
    abort_s[dut] = 1'b0;
    valid_s[dut] = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      m_pidx[i] = 3'd0;
      m_done[i] = 1'b0;
      m_to[i]   = 1'b0;
      m_ab[i]   = 1'b0;
    end
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      valid_s[i] = '0;
    end
    clear_model();
    #7;
    for (int i = 0; i < 3; i++) check($sformatf("reset_dut%0d", i), obs[i], 11'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full quiet sequence, then abort in the 2nd inject cycle of mode 2.
    gen_seq(0, 5'b11110, 4, 8, 16, -1, 0);
    run_q(0, 1000);
    gen_seq(0, 5'b11110, 4, 8, 16, 2, 2);
    run_q(0, 1000);
    for (int s = 0; s < 12; s++) begin
      gen_seq(0, 5'b11110, 4, 8, 16,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : -1,
              int'($urandom_range(1, 4)));
      run_q(0, 1000);
    end

    // Asynchronous reset while injecting, then a fresh start from mode 1.
    gen_seq(0, 5'b11110, 4, 8, 16, -1, 0);
    run_q(0, 4);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("async_rst_dut%0d", i), obs[i], 11'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    gen_seq(0, 5'b11110, 4, 8, 16, -1, 0);
    run_q(0, 1000);

    // Empty mask with looping, twice back to back.
    for (int s = 0; s < 2; s++) begin
      gen_seq(1, 5'b00000, 4, 8, 16, -1, 0);
      run_q(1, 1000);
    end

    // Zero phase length behaves as a single inject cycle.
    for (int s = 0; s < 4; s++) begin
      gen_seq(2, 5'b00010, 0, 8, 16, -1, 0);
      run_q(2, 1000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
